// File: rtl/adc_conv_model.sv
// adc_conv_model: behavioural ADC0809-style converter with START/EOC handshake
// Ports:
//   i_clk      bench clock, all logic on the rising edge
//   i_rst      asynchronous active-high reset
//   i_ale      address latch enable, i_addr captured on every edge while high
//   i_start    start strobe: rising edge arms, falling edge starts conversion
//   i_oe       output enable, gates the result onto o_data_out
//   i_addr     channel select
//   i_ch_data  flattened channel codes, channel k at [k*DATA_W +: DATA_W]
//   o_data_out result register when i_oe=1, else zero
//   o_eoc      1 = idle/result valid, 0 = converting
//   o_busy     high in any non-idle state
// Optional: define ADC_DITHER_EN to add LFSR-driven +/-1 dither to each result.
module adc_conv_model #(
    parameter int DATA_W      = 8,
    parameter int CH_N        = 8,
    parameter int ADDR_W      = 3,
    parameter int CONV_CYCLES = 64,
    parameter int EOC_DLY     = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_ale,
    input  logic                     i_start,
    input  logic                     i_oe,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic [CH_N*DATA_W-1:0]   i_ch_data,
    output logic [DATA_W-1:0]        o_data_out,
    output logic                     o_eoc,
    output logic                     o_busy
);
    localparam int CW = $clog2(CONV_CYCLES);

    typedef enum logic [1:0] {IDLE, ARM, CONV, DONE} state_t;

    state_t             r_state, w_state_n;
    logic               r_start_q;
    logic [ADDR_W-1:0]  r_addr_q;
    logic [3:0]         r_dly_cnt, w_dly_n;
    logic [CW-1:0]      r_conv_cnt, w_conv_n;
    logic               r_eoc, w_eoc_n;
    logic               w_load, w_commit, w_rise, w_fall;
    logic [DATA_W-1:0]  r_sample, r_result, w_res;
    logic [DATA_W-1:0]  w_ch [2**ADDR_W];

    assign w_rise = i_start & ~r_start_q;
    assign w_fall = ~i_start & r_start_q;

    // Addresses beyond CH_N read as a zero code.
    genvar k;
    for (k = 0; k < 2**ADDR_W; k++) begin : g_ch
        if (k < CH_N) begin : g_in
            assign w_ch[k] = i_ch_data[k*DATA_W +: DATA_W];
        end else begin : g_oor
            assign w_ch[k] = '0;
        end
    end

`ifdef ADC_DITHER_EN
    logic [15:0] r_lfsr;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_lfsr <= 16'hACE1;
        else
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
    // Dither saturates rather than wrapping at the code range limits.
    always_comb begin
        w_res = (r_lfsr[1:0] == 2'b01 && r_sample != '1) ? r_sample + DATA_W'(1) :
                (r_lfsr[1:0] == 2'b10 && r_sample != '0) ? r_sample - DATA_W'(1) : r_sample;
    end
`else
    assign w_res = r_sample;
`endif

    // eoc is registered: an ARM entered by restart keeps eoc low, since eoc
    // only holds its previous level until the delay expires.
    always_comb begin
        w_state_n = r_state;
        w_dly_n   = r_dly_cnt;
        w_conv_n  = r_conv_cnt;
        w_eoc_n   = r_eoc;
        w_load    = 1'b0;
        w_commit  = 1'b0;
        if (w_rise) begin
            w_state_n = ARM;
            w_dly_n   = 4'(EOC_DLY);
            w_eoc_n   = (EOC_DLY == 0) ? 1'b0 : r_eoc;
        end else begin
            case (r_state)
                IDLE: w_eoc_n = 1'b1;
                ARM: begin
                    if (w_fall) begin
                        w_state_n = CONV;
                        w_conv_n  = CW'(CONV_CYCLES - 1);
                        w_eoc_n   = 1'b0;
                        w_load    = 1'b1;
                    end else begin
                        w_dly_n = (r_dly_cnt != 4'd0) ? r_dly_cnt - 4'd1 : 4'd0;
                        w_eoc_n = (w_dly_n == 4'd0) ? 1'b0 : r_eoc;
                    end
                end
                CONV: begin
                    w_eoc_n   = 1'b0;
                    w_state_n = (r_conv_cnt == '0) ? DONE : CONV;
                    w_conv_n  = (r_conv_cnt == '0) ? r_conv_cnt : r_conv_cnt - CW'(1);
                end
                default: begin
                    w_state_n = IDLE;
                    w_eoc_n   = 1'b1;
                    w_commit  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_start_q  <= 1'b0;
            r_addr_q   <= '0;
            r_dly_cnt  <= '0;
            r_conv_cnt <= '0;
            r_eoc      <= 1'b1;
            r_sample   <= '0;
            r_result   <= '0;
        end else begin
            r_state    <= w_state_n;
            r_start_q  <= i_start;
            r_dly_cnt  <= w_dly_n;
            r_conv_cnt <= w_conv_n;
            r_eoc      <= w_eoc_n;
            if (i_ale)
                r_addr_q <= i_addr;
            if (w_load)
                r_sample <= w_ch[r_addr_q];
            if (w_commit)
                r_result <= w_res;
        end
    end

    assign o_data_out = i_oe ? r_result : '0;
    assign o_eoc      = r_eoc;
    assign o_busy     = (r_state != IDLE);
endmodule

// File: doc/adc_conv_model.md
Name: adc_conv_model

Overview:
- Parametrised behavioural successor of the bench ADC0809-style converter model, used by the 8048 testbench to feed analog channel codes (MAP, temperature, battery and similar) to the DME/KLR firmware.
- Adds the following over the previous model:
  - configurable width, channel count and conversion time;
  - a proper start/EOC handshake with a conversion state machine;
  - abort on restart;
  - out-of-range channel handling.
- Sits on the external bus model, driven by ALE/START/OE strobes decoded from port writes.

Parameters:
- DATA_W, 8: result/channel code width in bits.
- CH_N, 8: number of analog channels, 1..2**ADDR_W.
- ADDR_W, 3: channel address width.
- CONV_CYCLES, 64: clk cycles from conversion start to result ready, >=2.
- EOC_DLY, 2: clk cycles from START rising edge until EOC drops, 0..8.

Ports:
- clk  in  1  bench clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ale  in  1  address latch enable; addr sampled on every clk edge while high.
- start  in  1  conversion start strobe; rising edge arms, falling edge starts.
- oe  in  1  output enable for data_out.
- addr  in  ADDR_W  channel select.
- ch_data  in  CH_N*DATA_W  flattened channel codes; channel k = bits [k*DATA_W +: DATA_W].
- data_out  out  DATA_W  result register when oe=1, else all zeros.
- eoc  out  1  end of conversion: 1 = idle/result valid, 0 = converting.
- busy  out  1  high in any non-IDLE state.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, addr_q=0, result=0, counters=0;
  - data_out=0, eoc=1, busy=0.
- Address latch: addr_q<=addr on each clk edge with ale=1; holds otherwise. ale and start may be asserted together; addr_q then updates on that same edge.
- Edge detection: start is registered once (start_q); rise = start & ~start_q, fall = ~start & start_q.
- State machine:
  - IDLE: on rise -> ARM; dly_cnt<=EOC_DLY.
  - ARM (start held high):
    - dly_cnt counts down to 0.
    - eoc stays 1 until dly_cnt reaches 0, then eoc=0.
    - On fall -> CONV: sample <= ch_data[addr_q], conv_cnt<=CONV_CYCLES-1, eoc forced 0.
  - CONV:
    - conv_cnt decrements each cycle.
    - At conv_cnt==0 -> DONE: result<=sample.
  - DONE: one cycle, eoc<=1, -> IDLE.
- Latency: result visible on data_out (with oe=1) and eoc=1 exactly CONV_CYCLES+1 clk edges after the edge that detects fall.
- Sampling: the channel value is captured at conversion start. Later ch_data or addr changes do not affect the in-flight result.
- Out-of-range addr_q (addr_q >= CH_N): sampled code = 0.
- Restart: a rise in ARM, CONV or DONE aborts the current conversion and re-enters ARM with dly_cnt reloaded. The result register keeps the previous value; eoc follows the ARM rules.
- Zero-width start (rise and fall undetected, pulse shorter than clk): ignored.
- oe is purely combinational gating of result and independent of state. Reading during a conversion returns the previous result.
- EOC_DLY=0: eoc drops on the rise-detect edge.
- Reset mid-conversion: immediate return to reset values; the conversion is discarded.

Optional Feature:
- Macro ADC_DITHER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 at reset) advances each clk.
  - At DONE, result = sample + d, with d from LFSR[1:0]: 2'b01 -> +1, 2'b10 -> -1, otherwise 0.
  - Saturates at 0 and 2**DATA_W-1.
- Undefined: no LFSR, result = sample exactly.

Test Plan:
- Reset: rst pulse mid-CONV -> data_out=0 (oe=1), eoc=1, busy=0 immediately, without waiting for clk.
- Basic conversion (CONV_CYCLES=64): ch_data ch3=8'hA5, ale with addr=3, start 4 cycles high then low, oe=1 -> eoc low 2 edges after the rise edge; data_out=8'hA5 and eoc=1 at fall-detect edge +65.
- Capture timing: change ch3 to 8'h11 10 cycles into CONV -> result still 8'hA5; next conversion returns 8'h11.
- Restart abort: second start rise at conv_cnt=20 with addr=5, ch5=8'h3C -> no intermediate eoc=1; final data_out=8'h3C; the aborted value is never presented.
- Out-of-range/oe: CH_N=6, addr=7 -> data_out=8'h00 after conversion; oe=0 at any time -> data_out=8'h00.
- ADC_DITHER_EN: ch0=8'hFF and ch0=8'h00 over 50 conversions each -> results stay in {FE,FF} and {00,01}; no wrap-around.
